// File: rtl/bram_access_scheduler.sv
// rtl/bram_access_scheduler.sv - round-robin port-A arbiter for two masters plus a zero-fill engine
module bram_access_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  clr_start,
  input  logic [ADDR_WIDTH-1:0] clr_base,
  input  logic [ADDR_WIDTH:0]   clr_len,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic [ADDR_WIDTH:0]     len_sat;
  logic                    arb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      clr_addr_q   <= '0;
      clr_cnt_q    <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_addr_q   <= clr_addr_d;
      clr_cnt_q    <= clr_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Fill engine next-state
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_cnt_d  = clr_cnt_q;
    len_sat    = (clr_len > LEN_MAX) ? LEN_MAX : clr_len;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          if (clr_len == LEN_ZERO) begin
            state_d = DONE;
          end else begin
            state_d    = CLEAR;
            clr_addr_d = clr_base;
            clr_cnt_d  = len_sat;
          end
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_ONE;
        clr_cnt_d  = clr_cnt_q - LEN_ONE;
        if (clr_cnt_q == LEN_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration, port A mux and read return
  always_comb begin
    arb_en       = (state_q != CLEAR) && !rst;
    m0_gnt       = arb_en && m0_req && (!m1_req || last_grant_q);
    m1_gnt       = arb_en && m1_req && !m0_gnt;
    last_grant_d = last_grant_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    if (state_q == CLEAR) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = clr_addr_q;
    end else if (m0_gnt) begin
      mem_en       = 1'b1;
      mem_we       = m0_we;
      mem_addr     = m0_addr;
      mem_din      = m0_din;
      last_grant_d = 1'b0;
    end else if (m1_gnt) begin
      mem_en       = 1'b1;
      mem_we       = m1_we;
      mem_addr     = m1_addr;
      mem_din      = m1_din;
      last_grant_d = 1'b1;
    end
    rvalid0_d = m0_gnt && !m0_we;
    rvalid1_d = m1_gnt && !m1_we;
    // Read data is live from the pool in the valid cycle, then held locally
    m0_rdata  = rvalid0_q ? mem_dout : rdata0_q;
    m1_rdata  = rvalid1_q ? mem_dout : rdata1_q;
    rdata0_d  = m0_rdata;
    rdata1_d  = m1_rdata;
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = (state_q == DONE);

endmodule
